// File: rtl/sysmon_drp_arbiter.sv
// SYSMON DRP port owner: arbitrates EOC channel readback against host DRP access.
// Optional temperature min/max tracking is enabled by defining SYSMON_TEMP_MINMAX_EN.
module sysmon_drp_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              s_clk,
    input  logic              s_rst_n,
    input  logic              sm_eoc,
    input  logic [5:0]        sm_channel,
    input  logic              sm_drdy,
    input  logic [15:0]       sm_do,
    output logic              sm_den,
    output logic              sm_dwe,
    output logic [ADDR_W-1:0] sm_daddr,
    output logic [15:0]       sm_di,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [15:0]       host_wdata,
    output logic              host_ack,
    output logic [15:0]       host_rdata,
    output logic              host_err,
    output logic [9:0]        temp,
    output logic [9:0]        vccint,
    output logic [9:0]        vccaux,
    output logic [9:0]        vp,
    output logic [3:0]        upd,
`ifdef SYSMON_TEMP_MINMAX_EN
    input  logic              clr_minmax,
    output logic [9:0]        temp_min,
    output logic [9:0]        temp_max,
`endif
    output logic              eoc_overrun
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state, state_nxt;
    logic              grant_host, grant_host_nxt;
    logic              last_host, last_host_nxt;
    logic              cur_we, cur_we_nxt;
    logic [5:0]        cur_ch, cur_ch_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              timed_out, timed_out_nxt;
    logic [15:0]       rd_data, rd_data_nxt;
    logic              eoc_pend, eoc_pend_nxt;
    logic [5:0]        eoc_ch, eoc_ch_nxt;

    logic              sm_den_nxt, sm_dwe_nxt;
    logic [ADDR_W-1:0] sm_daddr_nxt;
    logic [15:0]       sm_di_nxt;
    logic              host_ack_nxt, host_err_nxt;
    logic [15:0]       host_rdata_nxt;
    logic [9:0]        temp_nxt, vccint_nxt, vccaux_nxt, vp_nxt;
    logic [3:0]        upd_nxt;
    logic              eoc_overrun_nxt;
`ifdef SYSMON_TEMP_MINMAX_EN
    logic [9:0]        temp_min_nxt, temp_max_nxt;
`endif

    // An EOC arriving this cycle already competes in arbitration.
    logic       eoc_pend_eff, host_eff, pick_host;
    logic [5:0] eoc_ch_eff;
    assign eoc_pend_eff = eoc_pend | sm_eoc;
    assign eoc_ch_eff   = sm_eoc ? sm_channel : eoc_ch;
    // The ack cycle still sees host_req high; do not restart on it.
    assign host_eff     = host_req & ~host_ack;
    assign pick_host    = host_eff & (~eoc_pend_eff | ~last_host);

    always_comb begin
        state_nxt       = state;
        grant_host_nxt  = grant_host;
        last_host_nxt   = last_host;
        cur_we_nxt      = cur_we;
        cur_ch_nxt      = cur_ch;
        cnt_nxt         = cnt;
        timed_out_nxt   = timed_out;
        rd_data_nxt     = rd_data;
        eoc_pend_nxt    = eoc_pend;
        eoc_ch_nxt      = eoc_ch;
        sm_den_nxt      = 1'b0;
        sm_dwe_nxt      = 1'b0;
        sm_daddr_nxt    = sm_daddr;
        sm_di_nxt       = sm_di;
        host_ack_nxt    = 1'b0;
        host_rdata_nxt  = host_rdata;
        host_err_nxt    = host_err;
        temp_nxt        = temp;
        vccint_nxt      = vccint;
        vccaux_nxt      = vccaux;
        vp_nxt          = vp;
        upd_nxt         = 4'b0000;
        eoc_overrun_nxt = eoc_overrun;
`ifdef SYSMON_TEMP_MINMAX_EN
        temp_min_nxt    = temp_min;
        temp_max_nxt    = temp_max;
`endif

        // EOC latch; a pending EOC not being consumed this cycle is lost.
        if (sm_eoc) begin
            eoc_pend_nxt = 1'b1;
            eoc_ch_nxt   = sm_channel;
            if (eoc_pend && !((state == S_ISSUE) && !grant_host)) begin
                eoc_overrun_nxt = 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (eoc_pend_eff || host_eff) begin
                    state_nxt      = S_ISSUE;
                    grant_host_nxt = pick_host;
                    last_host_nxt  = pick_host;
                    sm_den_nxt     = 1'b1;
                    if (pick_host) begin
                        sm_daddr_nxt = host_addr;
                        sm_dwe_nxt   = host_we;
                        sm_di_nxt    = host_wdata;
                        cur_we_nxt   = host_we;
                    end else begin
                        sm_daddr_nxt = ADDR_W'(eoc_ch_eff);
                        cur_ch_nxt   = eoc_ch_eff;
                        cur_we_nxt   = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                cnt_nxt       = '0;
                timed_out_nxt = 1'b0;
                state_nxt     = S_WAIT;
                if (!grant_host) begin
                    eoc_pend_nxt = sm_eoc;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (sm_drdy) begin
                    rd_data_nxt = sm_do;
                    state_nxt   = S_DONE;
                end else if (cnt_nxt == CNT_LAST) begin
                    timed_out_nxt = 1'b1;
                    state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                if (grant_host) begin
                    host_ack_nxt   = 1'b1;
                    host_err_nxt   = timed_out;
                    host_rdata_nxt = (cur_we || timed_out) ? 16'h0000 : rd_data;
                end else if (!timed_out) begin
                    case (cur_ch)
                        6'd0: begin
                            temp_nxt   = rd_data[15:6];
                            upd_nxt[0] = 1'b1;
`ifdef SYSMON_TEMP_MINMAX_EN
                            if (rd_data[15:6] < temp_min) temp_min_nxt = rd_data[15:6];
                            if (rd_data[15:6] > temp_max) temp_max_nxt = rd_data[15:6];
`endif
                        end
                        6'd1: begin
                            vccint_nxt = rd_data[15:6];
                            upd_nxt[1] = 1'b1;
                        end
                        6'd2: begin
                            vccaux_nxt = rd_data[15:6];
                            upd_nxt[2] = 1'b1;
                        end
                        6'd3: begin
                            vp_nxt     = rd_data[15:6];
                            upd_nxt[3] = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_nxt = S_IDLE;
        endcase

`ifdef SYSMON_TEMP_MINMAX_EN
        if (clr_minmax) begin
            temp_min_nxt = 10'h3FF;
            temp_max_nxt = 10'h000;
        end
`endif
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= S_IDLE;
            grant_host  <= 1'b0;
            last_host   <= 1'b1;
            cur_we      <= 1'b0;
            cur_ch      <= '0;
            cnt         <= '0;
            timed_out   <= 1'b0;
            rd_data     <= '0;
            eoc_pend    <= 1'b0;
            eoc_ch      <= '0;
            sm_den      <= 1'b0;
            sm_dwe      <= 1'b0;
            sm_daddr    <= '0;
            sm_di       <= '0;
            host_ack    <= 1'b0;
            host_rdata  <= '0;
            host_err    <= 1'b0;
            temp        <= '0;
            vccint      <= '0;
            vccaux      <= '0;
            vp          <= '0;
            upd         <= '0;
            eoc_overrun <= 1'b0;
`ifdef SYSMON_TEMP_MINMAX_EN
            temp_min    <= 10'h3FF;
            temp_max    <= 10'h000;
`endif
        end else begin
            state       <= state_nxt;
            grant_host  <= grant_host_nxt;
            last_host   <= last_host_nxt;
            cur_we      <= cur_we_nxt;
            cur_ch      <= cur_ch_nxt;
            cnt         <= cnt_nxt;
            timed_out   <= timed_out_nxt;
            rd_data     <= rd_data_nxt;
            eoc_pend    <= eoc_pend_nxt;
            eoc_ch      <= eoc_ch_nxt;
            sm_den      <= sm_den_nxt;
            sm_dwe      <= sm_dwe_nxt;
            sm_daddr    <= sm_daddr_nxt;
            sm_di       <= sm_di_nxt;
            host_ack    <= host_ack_nxt;
            host_rdata  <= host_rdata_nxt;
            host_err    <= host_err_nxt;
            temp        <= temp_nxt;
            vccint      <= vccint_nxt;
            vccaux      <= vccaux_nxt;
            vp          <= vp_nxt;
            upd         <= upd_nxt;
            eoc_overrun <= eoc_overrun_nxt;
`ifdef SYSMON_TEMP_MINMAX_EN
            temp_min    <= temp_min_nxt;
            temp_max    <= temp_max_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sysmon_drp_arbiter.sv
// Directed bench for sysmon_drp_arbiter; covers SYSMON_TEMP_MINMAX_EN when defined.
module tb_sysmon_drp_arbiter;

    logic        s_clk;
    logic        s_rst_n;
    logic        sm_eoc;
    logic [5:0]  sm_channel;
    logic        sm_drdy;
    logic [15:0] sm_do;
    logic        sm_den;
    logic        sm_dwe;
    logic [7:0]  sm_daddr;
    logic [15:0] sm_di;
    logic        host_req;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        host_err;
    logic [9:0]  temp, vccint, vccaux, vp;
    logic [3:0]  upd;
    logic        eoc_overrun;
`ifdef SYSMON_TEMP_MINMAX_EN
    logic        clr_minmax;
    logic [9:0]  temp_min, temp_max;
`endif

    int n_err = 0;
    int n_chk = 0;

    sysmon_drp_arbiter #(.TIMEOUT_CYC(64), .ADDR_W(8)) dut (
        .s_clk       (s_clk),
        .s_rst_n     (s_rst_n),
        .sm_eoc      (sm_eoc),
        .sm_channel  (sm_channel),
        .sm_drdy     (sm_drdy),
        .sm_do       (sm_do),
        .sm_den      (sm_den),
        .sm_dwe      (sm_dwe),
        .sm_daddr    (sm_daddr),
        .sm_di       (sm_di),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .host_err    (host_err),
        .temp        (temp),
        .vccint      (vccint),
        .vccaux      (vccaux),
        .vp          (vp),
        .upd         (upd),
`ifdef SYSMON_TEMP_MINMAX_EN
        .clr_minmax  (clr_minmax),
        .temp_min    (temp_min),
        .temp_max    (temp_max),
`endif
        .eoc_overrun (eoc_overrun)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // From the current cycle, wait n cycles then present one DRDY beat.
    task automatic drdy_after(input int n, input logic [15:0] d);
        for (int i = 0; i < n; i++) tick();
        sm_drdy = 1'b1;
        sm_do   = d;
        tick();
        sm_drdy = 1'b0;
        sm_do   = 16'h0000;
    endtask

    // One uncontended EOC readback; returns in the cycle where upd is visible.
    task automatic eoc_serve(input logic [5:0] ch, input logic [15:0] d, input int n);
        sm_eoc     = 1'b1;
        sm_channel = ch;
        tick();
        sm_eoc = 1'b0;
        chk("eoc_den", 32'(sm_den), 32'd1);
        chk("eoc_daddr", 32'(sm_daddr), 32'(ch));
        drdy_after(n, d);
        tick();
    endtask

    int cyc;
    int dens;

    initial begin
        s_rst_n    = 1'b0;
        sm_eoc     = 1'b0;
        sm_channel = 6'd0;
        sm_drdy    = 1'b0;
        sm_do      = 16'h0000;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 8'h00;
        host_wdata = 16'h0000;
`ifdef SYSMON_TEMP_MINMAX_EN
        clr_minmax = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_drp", {14'd0, sm_den, sm_dwe, sm_di}, 32'd0);
        chk("rst_daddr", 32'(sm_daddr), 32'd0);
        chk("rst_host", {15'd0, host_ack, host_rdata}, 32'd0);
        chk("rst_chan", {2'd0, temp, vccint, vccaux}, 32'd0);
        chk("rst_misc", {17'd0, host_err, eoc_overrun, upd, vp}, 32'd0);
`ifdef SYSMON_TEMP_MINMAX_EN
        chk("rst_minmax", {12'd0, temp_min, temp_max}, {12'd0, 10'h3FF, 10'h000});
`endif
        s_rst_n = 1'b1;
        tick();

        // Single EOC ch1, DRDY 5 cycles after DEN.
        sm_eoc = 1'b1; sm_channel = 6'd1;
        tick();
        sm_eoc = 1'b0;
        chk("t1_den", 32'(sm_den), 32'd1);
        chk("t1_daddr", 32'(sm_daddr), 32'h01);
        chk("t1_dwe", 32'(sm_dwe), 32'd0);
        drdy_after(5, 16'hA5C0);
        tick();
        chk("t1_vccint", 32'(vccint), 32'h297);
        chk("t1_upd", 32'(upd), 32'b0010);
        tick();
        chk("t1_upd_clr", 32'(upd), 32'b0000);

        // Host write.
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h42; host_wdata = 16'h4000;
        tick();
        chk("t2_den_dwe", {30'd0, sm_den, sm_dwe}, 32'b11);
        chk("t2_daddr", 32'(sm_daddr), 32'h42);
        chk("t2_di", 32'(sm_di), 32'h4000);
        drdy_after(3, 16'h1234);
        tick();
        chk("t2_ack", 32'(host_ack), 32'd1);
        chk("t2_err", 32'(host_err), 32'd0);
        chk("t2_rdata", 32'(host_rdata), 32'h0);
        host_req = 1'b0;
        tick();
        chk("t2_ack_pulse", {30'd0, host_ack, sm_den}, 32'd0);

        // Contention: EOC first, host second, then host wins the next contention.
        sm_eoc = 1'b1; sm_channel = 6'd0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        tick();
        chk("t3_eoc_first", {23'd0, sm_den, sm_daddr}, {23'd0, 1'b1, 8'h00});
        sm_eoc = 1'b1; sm_channel = 6'd0;
        tick();
        sm_eoc = 1'b0;
        drdy_after(1, 16'hFFC0);
        tick();
        chk("t3_temp", 32'(temp), 32'h3FF);
        chk("t3_upd", 32'(upd), 32'b0001);
        chk("t3_no_ovr", 32'(eoc_overrun), 32'd0);
        tick();
        chk("t3_host_second", {23'd0, sm_den, sm_daddr}, {23'd0, 1'b1, 8'h10});
        drdy_after(1, 16'hBEEF);
        tick();
        chk("t3_ack", 32'(host_ack), 32'd1);
        chk("t3_rdata", 32'(host_rdata), 32'hBEEF);
        host_req = 1'b0;
        tick();
        chk("t3_eoc_third", {23'd0, sm_den, sm_daddr}, {23'd0, 1'b1, 8'h00});
        drdy_after(1, 16'h0040);
        tick();
        chk("t3_temp2", {22'd0, upd, temp}, {22'd0, 4'b0001, 10'h001});

        // DRDY outside WAIT must do nothing.
        sm_drdy = 1'b1; sm_do = 16'hFFFF;
        tick();
        sm_drdy = 1'b0; sm_do = 16'h0000;
        tick();
        chk("stray_drdy", {26'd0, host_ack, sm_den, upd}, 32'd0);

        // Host read timeout.
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        tick();
        chk("t4_den", 32'(sm_den), 32'd1);
        cyc  = 0;
        dens = 0;
        while (!host_ack && cyc < 100) begin
            tick();
            cyc++;
            if (sm_den) dens++;
        end
        chk("t4_latency", 32'(cyc), 32'd65);
        chk("t4_err", 32'(host_err), 32'd1);
        chk("t4_rdata", 32'(host_rdata), 32'h0);
        chk("t4_no_den", 32'(dens), 32'd0);
        host_req = 1'b0;
        tick();
        eoc_serve(6'd3, 16'h8000, 2);
        chk("t4_vp", {22'd0, upd, vp}, {22'd0, 4'b1000, 10'h200});

        // EOC overrun while host transaction waits.
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
        tick();
        tick();
        sm_eoc = 1'b1; sm_channel = 6'd2;
        tick();
        sm_eoc = 1'b1; sm_channel = 6'd3;
        tick();
        sm_eoc = 1'b0;
        chk("t5_overrun", 32'(eoc_overrun), 32'd1);
        drdy_after(0, 16'h1111);
        tick();
        chk("t5_ack", {15'd0, host_ack, host_rdata}, {15'd0, 1'b1, 16'h1111});
        host_req = 1'b0;
        tick();
        chk("t5_daddr", {23'd0, sm_den, sm_daddr}, {23'd0, 1'b1, 8'h03});
        drdy_after(1, 16'hFFC0);
        tick();
        chk("t5_vp", {22'd0, upd, vp}, {22'd0, 4'b1000, 10'h3FF});
        chk("t5_vccaux", 32'(vccaux), 32'd0);
        chk("t5_overrun_sticky", 32'(eoc_overrun), 32'd1);

`ifdef SYSMON_TEMP_MINMAX_EN
        clr_minmax = 1'b1;
        tick();
        clr_minmax = 1'b0;
        eoc_serve(6'd0, 16'h4B00, 1);
        eoc_serve(6'd0, 16'h4600, 1);
        eoc_serve(6'd0, 16'h4D80, 1);
        chk("mm_temp", 32'(temp), 32'd310);
        chk("mm_min", 32'(temp_min), 32'd280);
        chk("mm_max", 32'(temp_max), 32'd310);
        clr_minmax = 1'b1;
        tick();
        clr_minmax = 1'b0;
        chk("mm_clr", {12'd0, temp_min, temp_max}, {12'd0, 10'h3FF, 10'h000});
`endif

        // Reset in the middle of a transaction.
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h55; host_wdata = 16'hAAAA;
        tick();
        tick();
        s_rst_n  = 1'b0;
        host_req = 1'b0;
        #1;
        chk("rst_mid", {27'd0, host_ack, sm_den, sm_dwe, eoc_overrun, host_err}, 32'd0);
        #1;
        s_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_mid_idle", {30'd0, host_ack, sm_den}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
